// File: rtl/sys_output_deskew.sv
// Output deskew for the systolic array: per-column FIFOs realign staggered column words into whole rows.
// Optional build macro SYS_DESKEW_RELU_EN applies ReLU to each enabled lane as it enters the output register.
module sys_output_deskew #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 2,
    parameter int DATA_WIDTH           = 16,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] col_data_in,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]            col_valid_in,
    input  logic [15:0]                                ub_rd_col_size_in,
    input  logic                                       ub_rd_col_size_valid_in,
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH-1:0] row_data_out,
    output logic                                       row_valid_out,
    input  logic                                       row_ready_in,
    output logic                                       overflow_err,
    output logic [15:0]                                rows_drained,
    output logic                                       busy
);
    localparam int W  = SYSTOLIC_ARRAY_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_r [W][FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_r [W];
    logic [AW-1:0]         rd_ptr_r [W];
    logic [CW-1:0]         cnt_r [W];
    logic [CW-1:0]         cnt_next_s [W];
    logic [W-1:0]          mask_r;
    logic [W-1:0]          mask_next_s;
    logic [W-1:0]          push_req_s;
    logic [W-1:0]          push_ok_s;
    logic [W-1:0]          pop_s;
    logic                  all_avail_s;
    logic                  row_ready_int_s;
    logic                  load_s;
    logic                  handoff_s;
    logic                  valid_next_s;
    logic                  busy_next_s;
    logic                  overflow_s;
    logic [W*DATA_WIDTH-1:0] load_data_s;
    logic [W*DATA_WIDTH-1:0] row_data_r;
    logic                  row_valid_r;
    logic                  overflow_r;
    logic [15:0]           rows_drained_r;
    logic                  busy_r;

    function automatic logic [DATA_WIDTH-1:0] relu_f(input logic [DATA_WIDTH-1:0] v);
        if (v[DATA_WIDTH-1]) begin
            relu_f = {DATA_WIDTH{1'b0}};
        end else begin
            relu_f = v;
        end
    endfunction

    // Enable mask candidate: column c is enabled when the requested size exceeds c (clamps at W).
    always_comb begin
        mask_next_s = {W{1'b0}};
        for (int c = 0; c < W; c++) begin
            mask_next_s[c] = (ub_rd_col_size_in > 16'(c));
        end
    end

    // Row assembly, push/pop arbitration and next-state counts.
    always_comb begin
        all_avail_s = 1'b1;
        for (int c = 0; c < W; c++) begin
            if (mask_r[c] && (cnt_r[c] == {CW{1'b0}})) begin
                all_avail_s = 1'b0;
            end else begin
                all_avail_s = all_avail_s;
            end
        end
        row_ready_int_s = all_avail_s && (mask_r != {W{1'b0}});
        load_s          = row_ready_int_s && (!row_valid_r || row_ready_in);
        handoff_s       = row_valid_r && row_ready_in;
        pop_s           = load_s ? mask_r : {W{1'b0}};
        push_req_s      = mask_r & col_valid_in;
        busy_next_s     = 1'b0;
        load_data_s     = {(W*DATA_WIDTH){1'b0}};
        for (int c = 0; c < W; c++) begin
            // A full FIFO still accepts a word when it is popped on the same edge.
            push_ok_s[c] = push_req_s[c] && ((cnt_r[c] < CW'(FIFO_DEPTH)) || pop_s[c]);
            case ({push_ok_s[c], pop_s[c]})
                2'b10:   cnt_next_s[c] = cnt_r[c] + CW'(1);
                2'b01:   cnt_next_s[c] = cnt_r[c] - CW'(1);
                default: cnt_next_s[c] = cnt_r[c];
            endcase
            busy_next_s = busy_next_s || (cnt_next_s[c] != {CW{1'b0}});
            if (mask_r[c]) begin
`ifdef SYS_DESKEW_RELU_EN
                load_data_s[c*DATA_WIDTH +: DATA_WIDTH] = relu_f(mem_r[c][rd_ptr_r[c]]);
`else
                load_data_s[c*DATA_WIDTH +: DATA_WIDTH] = mem_r[c][rd_ptr_r[c]];
`endif
            end else begin
                load_data_s[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end
        end
        overflow_s = |(push_req_s & ~push_ok_s);
        if (load_s) begin
            valid_next_s = 1'b1;
        end else if (handoff_s) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = row_valid_r;
        end
        busy_next_s = busy_next_s || valid_next_s;
    end

    // FIFO storage; contents need no reset because pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < W; c++) begin
            if (push_ok_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= col_data_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Control state: pointers, counts, mask, output register and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < W; c++) begin
                wr_ptr_r[c] <= {AW{1'b0}};
                rd_ptr_r[c] <= {AW{1'b0}};
                cnt_r[c]    <= {CW{1'b0}};
            end
            mask_r         <= {W{1'b0}};
            row_data_r     <= {(W*DATA_WIDTH){1'b0}};
            row_valid_r    <= 1'b0;
            overflow_r     <= 1'b0;
            rows_drained_r <= 16'd0;
            busy_r         <= 1'b0;
        end else begin
            for (int c = 0; c < W; c++) begin
                if (push_ok_s[c]) wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1);
                if (pop_s[c])     rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1);
                cnt_r[c] <= cnt_next_s[c];
            end
            if (ub_rd_col_size_valid_in && !busy_r) mask_r <= mask_next_s;
            if (load_s) row_data_r <= load_data_s;
            if (overflow_s) overflow_r <= 1'b1;
            if (handoff_s) rows_drained_r <= rows_drained_r + 16'd1;
            row_valid_r <= valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign row_data_out  = row_data_r;
    assign row_valid_out = row_valid_r;
    assign overflow_err  = overflow_r;
    assign rows_drained  = rows_drained_r;
    assign busy          = busy_r;
endmodule

// File: doc/sys_output_deskew.md
# sys_output_deskew

Drain-side companion to the systolic array: captures the diagonally staggered per-column partial-sum outputs from the bottom edge of the array (column c delivers its word for a given row c cycles after column 0) and re-aligns them into whole result rows. Per-column FIFOs absorb the skew, and a registered valid/ready port presents one aligned row per beat to the unified-buffer write path. Column enables follow the same `ub_rd_col_size` convention as the array, so disabled columns never stall row assembly.

## Interface
- `SYSTOLIC_ARRAY_WIDTH`, 2, number of array columns W (>=1)
- `DATA_WIDTH`, 16, bits per column word, signed two's complement
- `FIFO_DEPTH`, 4, entries per column FIFO, power of two, >= 2*W

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `col_data_in`  in  W*DATA_WIDTH  column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- `col_valid_in`  in  W  per-column valid from the array bottom edge
- `ub_rd_col_size_in`  in  16  number of enabled columns
- `ub_rd_col_size_valid_in`  in  1  load strobe for column size
- `row_data_out`  out  W*DATA_WIDTH  aligned row, same lane packing as input
- `row_valid_out`  out  1  row present on `row_data_out`
- `row_ready_in`  in  1  downstream accepts row when high with valid
- `overflow_err`  out  1  sticky: a valid word arrived at a full FIFO
- `rows_drained`  out  16  count of rows handed off, wraps at 2^16
- `busy`  out  1  any FIFO non-empty or `row_valid_out` high

## Operation
- Enable mask: on `ub_rd_col_size_valid_in` while `busy`=0, mask <= (1<<min(size,W))-1. Strobe while `busy`=1 is ignored. Reset mask = 0.
- Capture: for each enabled column c with `col_valid_in[c]`=1, push `col_data_in` lane c into FIFO c. Valids on disabled columns are ignored.
- Push is accepted if FIFO c count < FIFO_DEPTH, or if FIFO c is popped in the same cycle. Otherwise the word is dropped, `overflow_err` <= 1, and FIFO c is unchanged.
- Row assembly: `row_ready_int` = every enabled FIFO non-empty AND mask != 0.
- Load condition: `row_ready_int` AND (`row_valid_out`=0 OR `row_ready_in`=1).
- On load:
  - the output register takes all enabled FIFO heads; disabled lanes are 0;
  - every enabled FIFO pops exactly once;
  - `row_valid_out` <= 1.
- Handoff: `row_valid_out` AND `row_ready_in`:
  - `rows_drained` increments;
  - if no load occurs in the same cycle, `row_valid_out` <= 0.
- `row_data_out` holds stable while `row_valid_out`=1 and `row_ready_in`=0.
- Mask = 0: no rows are ever emitted and no words are captured.
- No arithmetic is applied to data except the optional feature below. Widths pass through unchanged.

## Timing
- Reset values: `row_valid_out`=0, `row_data_out`=0, `overflow_err`=0, `rows_drained`=0, `busy`=0, all FIFO pointers and counts 0, mask 0.
- Reset mid-operation discards all FIFO contents and any pending output row at the next edge.
- Latency: the last enabled column's word is sampled at edge N, and `row_valid_out`=1 is visible after edge N+1. Minimum latency is therefore 2 cycles.
- Throughput: one row per cycle sustained when `row_ready_in`=1 and skew is steady-state.
- Back-pressure: with `row_ready_in`=0, FIFOs fill. Overflow occurs only when a column receives FIFO_DEPTH+1 unpopped words.
- FIFO pointers wrap modulo FIFO_DEPTH. Full is count==FIFO_DEPTH; empty is count==0.
- `rows_drained` wraps 0xFFFF -> 0x0000.

## Configuration
- `SYS_DESKEW_RELU_EN`
  - Defined: each enabled lane is passed through ReLU when loaded into the output register (negative -> 0, MSB tested as sign).
  - Undefined: lanes pass through bit-exact.
- FIFO contents are always raw data; the macro affects only the output register.

## Test plan
- **Aligned skew:** size=2; col0 valid cycles 0-2 with 1,2,3; col1 valid cycles 1-3 with 10,20,30; ready=1 -> rows {1,10},{2,20},{3,30} on consecutive cycles, first at cycle 3; `rows_drained`=3.
- **Disabled column:** size=1; col0 pushes 7, col1 valid pushes 99 -> single row {7,0}; col1 FIFO stays empty.
- **Back-pressure and overflow:** DEPTH=4, size=2, ready=0; push 6 aligned rows -> one row held stable in the output register, 4 rows held in FIFOs, sixth dropped, `overflow_err`=1. Release ready -> rows 1-5 delivered in order; error stays 1 until `rst`.
- **Simultaneous push/pop at full:** FIFOs full, ready=1, new valid on the same edge -> accepted, no overflow, order preserved.
- **Config while busy and reset mid-row:** size strobe=1 while `busy` -> mask unchanged. Assert `rst` with 2 words queued -> next cycle all outputs at reset values; a subsequent strobe with size=2 then takes effect.
- **ReLU build:** with `SYS_DESKEW_RELU_EN`, input row {0xFFFE, 0x0005} -> {0x0000, 0x0005}; without it -> {0xFFFE, 0x0005}.
